// File: rtl/z_seq_detector.sv
// Samples the upstream z bit into a PAT_W-deep history, detects PATTERN and reports matches as valid/ready events.
// Optional macro Z_SEQ_NONOVERLAP_EN: a detected match clears the history so its bits cannot start another match.
module z_seq_detector #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int unsigned      IDX_W   = 8,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             clr,
    input  logic             z_valid,
    input  logic             z,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic [CNT_W-1:0] match_cnt,
    output logic             overflow
);

    localparam int unsigned     FW        = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FILL_LAST = FW'(PAT_W - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [PAT_W-1:0] sr;
    logic [PAT_W-1:0] sr_next;
    logic [FW-1:0]    fill_cnt;
    logic [IDX_W-1:0] smp_idx;
    logic             accept;
    logic             hit;

    // The sample completing the fill is already eligible for a match.
    always_comb begin
        accept  = z_valid & ~clr;
        sr_next = {sr[PAT_W-2:0], z};
        hit     = accept && ((state == ST_RUN) || (fill_cnt == FILL_LAST))
                  && (sr_next == PATTERN);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= ST_FILL;
            sr       <= '0;
            fill_cnt <= '0;
            smp_idx  <= '0;
        end else if (clr) begin
            state    <= ST_FILL;
            sr       <= '0;
            fill_cnt <= '0;
            smp_idx  <= '0;
        end else if (accept) begin
            smp_idx <= smp_idx + IDX_W'(1);
            sr      <= sr_next;
            if (state == ST_FILL) begin
                if (fill_cnt == FILL_LAST) begin
                    state <= ST_RUN;
                end else begin
                    fill_cnt <= fill_cnt + FW'(1);
                end
            end
`ifdef Z_SEQ_NONOVERLAP_EN
            if (hit) begin
                state    <= ST_FILL;
                sr       <= '0;
                fill_cnt <= '0;
            end
`endif
        end
    end

    // A match arriving while the previous event is still held (and not retiring) is dropped.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (hit) begin
                if (match_cnt != '1) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_idx   <= smp_idx;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule
